// File: rtl/pe_edc_scheduler.sv
// pe_edc_scheduler
//
// Sequencing controller for one binary conv/pool/binarize/unpool processing
// element (PE_EDC datapath). For every output kernel it fetches the weight set
// and binarization threshold. It then walks every pooled output position with
// the column innermost, and pulses the element input enable once per window.
// The one-hot unpooled result is registered and handed to the result writer
// over a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, abort      begin a pass (sampled in IDLE) / abandon the pass
//   cfg_s             comparator mode, latched on an accepted start
//   busy, done        not-IDLE indicator / one-cycle completion pulse
//   w_req, w_kidx     weight/threshold request and its kernel index
//   w_ack             weights and norm_ref_in valid this cycle
//   norm_ref_in       threshold of the current kernel
//   win_req           window request
//   win_row, win_col  address of the requested window
//   win_ack           window data present on the element input
//   pe_in_en          element input enable (COMPUTE only)
//   pe_s              element comparator mode for the whole pass
//   pe_norm_ref       registered threshold
//   pe_data_out       combinational element result
//   res_valid         result valid
//   res_ready         writer accepts the result
//   res_data          registered result
//   res_k/row/col     kernel/row/column tags of the result
module pe_edc_scheduler #(
   parameter int OUT_H         = 8,
   parameter int OUT_W         = 8,
   parameter int N_K           = 64,
   parameter int POOL_H        = 2,
   parameter int POOL_W        = 2,
   parameter int NORMREF_WIDTH = 14,
   localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1,
   localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1,
   localparam int KW = (N_K > 1) ? $clog2(N_K) : 1,
   localparam int PW = POOL_H * POOL_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     cfg_s,
   output logic                     busy,
   output logic                     done,
   output logic                     w_req,
   output logic [KW-1:0]            w_kidx,
   input  logic                     w_ack,
   input  logic [NORMREF_WIDTH-1:0] norm_ref_in,
   output logic                     win_req,
   output logic [RW-1:0]            win_row,
   output logic [CW-1:0]            win_col,
   input  logic                     win_ack,
   output logic                     pe_in_en,
   output logic                     pe_s,
   output logic [NORMREF_WIDTH-1:0] pe_norm_ref,
   input  logic [PW-1:0]            pe_data_out,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [PW-1:0]            res_data,
   output logic [KW-1:0]            res_k,
   output logic [RW-1:0]            res_row,
   output logic [CW-1:0]            res_col
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD_K  = 3'd1;
   localparam logic [2:0] ST_FETCH   = 3'd2;
   localparam logic [2:0] ST_COMPUTE = 3'd3;
   localparam logic [2:0] ST_EMIT    = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [KW-1:0] k_cnt;
   logic [RW-1:0] row_cnt;
   logic [CW-1:0] col_cnt;
   logic          col_last;
   logic          row_last;
   logic          k_last;
   logic          start_ok;
   logic          res_accept;

   assign col_last   = (col_cnt == CW'(OUT_W - 1));
   assign row_last   = (row_cnt == RW'(OUT_H - 1));
   assign k_last     = (k_cnt == KW'(N_K - 1));
   assign start_ok   = (state == ST_IDLE) && start && !abort;
   // A result handshake only counts when abort is not pulling the pass down
   // in the same cycle; abort must leave the counters untouched.
   assign res_accept = (state == ST_EMIT) && res_ready && !abort;

   // Strobes are decoded from the registered state alone so that no input
   // can reach them combinationally.
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign w_req     = (state == ST_LOAD_K);
   assign win_req   = (state == ST_FETCH);
   assign pe_in_en  = (state == ST_COMPUTE);
   assign res_valid = (state == ST_EMIT);

   // The request addresses are the loop counters themselves, so they stay
   // stable for as long as a request waits for its ack.
   assign w_kidx  = k_cnt;
   assign win_row = row_cnt;
   assign win_col = col_cnt;

   // Next-state selection. Abort overrides every other transition, which
   // also makes a start ignored in the cycle abort is high.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (start) state_nxt = ST_LOAD_K;
            ST_LOAD_K:  if (w_ack) state_nxt = ST_FETCH;
            ST_FETCH:   if (win_ack) state_nxt = ST_COMPUTE;
            ST_COMPUTE: state_nxt = ST_EMIT;
            ST_EMIT: begin
               if (res_ready) begin
                  if (col_last && row_last)
                     state_nxt = k_last ? ST_DONE : ST_LOAD_K;
                  else
                     state_nxt = ST_FETCH;
               end
            end
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
         endcase
      end
   end

   // State register. Reset drops straight back to IDLE, even mid-pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Loop counters, with the column innermost and the kernel outermost. A
   // wrap of the final position leaves k alone because the pass ends there
   // and the next start clears everything anyway.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_cnt   <= '0;
         row_cnt <= '0;
         col_cnt <= '0;
         pe_s    <= 1'b0;
      end else if (start_ok) begin
         k_cnt   <= '0;
         row_cnt <= '0;
         col_cnt <= '0;
         pe_s    <= cfg_s;
      end else if (res_accept) begin
         if (!col_last) begin
            col_cnt <= col_cnt + CW'(1);
         end else begin
            col_cnt <= '0;
            if (!row_last) begin
               row_cnt <= row_cnt + RW'(1);
            end else begin
               row_cnt <= '0;
               if (!k_last)
                  k_cnt <= k_cnt + KW'(1);
            end
         end
      end
   end

   // The threshold is only taken on an acknowledged kernel load, so it is
   // constant across all the positions of one kernel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pe_norm_ref <= '0;
      else if ((state == ST_LOAD_K) && w_ack && !abort)
         pe_norm_ref <= norm_ref_in;
   end

   // The result and its tags are snapshotted at the end of the single
   // COMPUTE cycle. From then on the element output is free to change while
   // the writer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_data <= '0;
         res_k    <= '0;
         res_row  <= '0;
         res_col  <= '0;
      end else if ((state == ST_COMPUTE) && !abort) begin
         res_data <= pe_data_out;
         res_k    <= k_cnt;
         res_row  <= row_cnt;
         res_col  <= col_cnt;
      end
   end

endmodule

// File: tb/tb_pe_edc_scheduler.sv
// tb_pe_edc_scheduler
//
// Bench for pe_edc_scheduler with a 2x3 output plane and two kernels. The
// upstream ack, ready and data inputs are driven with $urandom. A reference
// model keeps the expected (kernel,row,col) visiting order as a queue built
// from nested loops. It follows the handshakes to predict every request
// address, threshold, result and tag, and the done pulse.
module tb_pe_edc_scheduler;

   localparam int OUT_H  = 2;
   localparam int OUT_W  = 3;
   localparam int N_K    = 2;
   localparam int POOL_H = 2;
   localparam int POOL_W = 2;
   localparam int NRW    = 14;
   localparam int RW     = 1;
   localparam int CW     = 2;
   localparam int KW     = 1;
   localparam int PW     = 4;
   localparam int PASS_CYCLES = 1 + N_K * (1 + 3 * OUT_H * OUT_W);

   logic           clk;
   logic           rst_n;
   logic           start;
   logic           abort;
   logic           cfg_s;
   logic           busy;
   logic           done;
   logic           w_req;
   logic [KW-1:0]  w_kidx;
   logic           w_ack;
   logic [NRW-1:0] norm_ref_in;
   logic           win_req;
   logic [RW-1:0]  win_row;
   logic [CW-1:0]  win_col;
   logic           win_ack;
   logic           pe_in_en;
   logic           pe_s;
   logic [NRW-1:0] pe_norm_ref;
   logic [PW-1:0]  pe_data_out;
   logic           res_valid;
   logic           res_ready;
   logic [PW-1:0]  res_data;
   logic [KW-1:0]  res_k;
   logic [RW-1:0]  res_row;
   logic [CW-1:0]  res_col;

   pe_edc_scheduler #(
      .OUT_H(OUT_H), .OUT_W(OUT_W), .N_K(N_K),
      .POOL_H(POOL_H), .POOL_W(POOL_W), .NORMREF_WIDTH(NRW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_s(cfg_s),
      .busy(busy), .done(done), .w_req(w_req), .w_kidx(w_kidx), .w_ack(w_ack),
      .norm_ref_in(norm_ref_in), .win_req(win_req), .win_row(win_row),
      .win_col(win_col), .win_ack(win_ack), .pe_in_en(pe_in_en), .pe_s(pe_s),
      .pe_norm_ref(pe_norm_ref), .pe_data_out(pe_data_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_k(res_k), .res_row(res_row), .res_col(res_col)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Percent chance per cycle that each upstream/downstream partner answers.
   int wAckPct   = 100;
   int winAckPct = 100;
   int readyPct  = 100;

   typedef struct {
      int k;
      int r;
      int c;
   } pos_t;

   pos_t           expQ[$];
   pos_t           head;
   bit             passActive;
   bit             expectBusyRise;
   bit             expectIdle;
   bit             expectDone;
   bit             expectNormUpd;
   bit             expectCompute;
   int             inFlight;
   logic [NRW-1:0] expNorm;
   logic [PW-1:0]  capData;
   logic           expS;

   int             cycles;
   logic [PW-1:0]  savedData;

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // One cycle of start/abort/cfg_s, then the control inputs drop back.
   task automatic applyStimulus(input logic s, input logic a, input logic c);
      @(negedge clk);
      start = s;
      abort = a;
      cfg_s = c;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"},        32'(busy),        0);
      checkOutput({tag, "_done"},        32'(done),        0);
      checkOutput({tag, "_w_req"},       32'(w_req),       0);
      checkOutput({tag, "_w_kidx"},      32'(w_kidx),      0);
      checkOutput({tag, "_win_req"},     32'(win_req),     0);
      checkOutput({tag, "_win_row"},     32'(win_row),     0);
      checkOutput({tag, "_win_col"},     32'(win_col),     0);
      checkOutput({tag, "_pe_in_en"},    32'(pe_in_en),    0);
      checkOutput({tag, "_pe_s"},        32'(pe_s),        0);
      checkOutput({tag, "_pe_norm_ref"}, 32'(pe_norm_ref), 0);
      checkOutput({tag, "_res_valid"},   32'(res_valid),   0);
      checkOutput({tag, "_res_data"},    32'(res_data),    0);
      checkOutput({tag, "_res_k"},       32'(res_k),       0);
      checkOutput({tag, "_res_row"},     32'(res_row),     0);
      checkOutput({tag, "_res_col"},     32'(res_col),     0);
   endtask

   task automatic waitDone(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("wait_done", 32'(done), 1);
   endtask

   // Randomized partner behaviour, refreshed every falling edge.
   initial begin
      w_ack       = 1'b0;
      win_ack     = 1'b0;
      res_ready   = 1'b0;
      pe_data_out = '0;
      norm_ref_in = '0;
      forever begin
         @(negedge clk);
         w_ack       = (int'($urandom_range(99)) < wAckPct);
         win_ack     = (int'($urandom_range(99)) < winAckPct);
         res_ready   = (int'($urandom_range(99)) < readyPct);
         pe_data_out = PW'($urandom);
         norm_ref_in = NRW'($urandom);
      end
   end

   // Reference model, sampled 1 ns before each rising edge. The first half
   // checks consequences of the previous edge and the second half looks at
   // the handshakes about to complete.
   initial begin
      passActive     = 0;
      expectBusyRise = 0;
      expectIdle     = 0;
      expectDone     = 0;
      expectNormUpd  = 0;
      expectCompute  = 0;
      inFlight       = 0;
      expNorm        = '0;
      capData        = '0;
      expS           = 1'b0;
      forever begin
         @(negedge clk);
         #4;
         if (!rst_n) begin
            passActive     = 0;
            expectBusyRise = 0;
            expectIdle     = 0;
            expectDone     = 0;
            expectNormUpd  = 0;
            expectCompute  = 0;
            inFlight       = 0;
            expNorm        = '0;
            expQ.delete();
         end else begin
            if (expectBusyRise) begin
               checkOutput("busy_after_start", 32'(busy), 1);
               checkOutput("w_req_after_start", 32'(w_req), 1);
               checkOutput("pe_s_latched", 32'(pe_s), 32'(expS));
               expectBusyRise = 0;
            end
            if (expectIdle) begin
               checkOutput("busy_back_idle", 32'(busy), 0);
               checkOutput("res_valid_idle", 32'(res_valid), 0);
               expectIdle = 0;
            end
            checkOutput("done", 32'(done), 32'(expectDone));
            if (expectDone)
               expectIdle = 1;
            expectDone = 0;
            if (expectNormUpd) begin
               checkOutput("pe_norm_ref_load", 32'(pe_norm_ref), 32'(expNorm));
               expectNormUpd = 0;
            end
            checkOutput("pe_in_en", 32'(pe_in_en), 32'(expectCompute));
            if (pe_in_en) begin
               capData = pe_data_out;
               checkOutput("pe_s_compute", 32'(pe_s), 32'(expS));
            end
            expectCompute = 0;

            if (passActive) begin
               head = expQ[0];
               if (abort) begin
                  passActive = 0;
                  inFlight   = 0;
                  expectIdle = 1;
                  expQ.delete();
               end else begin
                  if (w_req) begin
                     checkOutput("w_kidx", 32'(w_kidx), 32'(head.k));
                     if (w_ack) begin
                        expNorm       = norm_ref_in;
                        expectNormUpd = 1;
                     end
                  end
                  if (win_req) begin
                     checkOutput("win_row", 32'(win_row), 32'(head.r));
                     checkOutput("win_col", 32'(win_col), 32'(head.c));
                     checkOutput("win_in_flight", 32'(inFlight), 0);
                     checkOutput("pe_norm_ref_stable", 32'(pe_norm_ref), 32'(expNorm));
                     if (win_ack) begin
                        expectCompute = 1;
                        inFlight      = 1;
                     end
                  end
                  if (res_valid) begin
                     checkOutput("res_data", 32'(res_data), 32'(capData));
                     checkOutput("res_k", 32'(res_k), 32'(head.k));
                     checkOutput("res_row", 32'(res_row), 32'(head.r));
                     checkOutput("res_col", 32'(res_col), 32'(head.c));
                     if (res_ready) begin
                        void'(expQ.pop_front());
                        inFlight = 0;
                        if (expQ.size() == 0) begin
                           expectDone = 1;
                           passActive = 0;
                        end
                     end
                  end
               end
            end else if (!busy && start && !abort) begin
               passActive     = 1;
               expectBusyRise = 1;
               expS           = cfg_s;
               expQ.delete();
               for (int k = 0; k < N_K; k++)
                  for (int r = 0; r < OUT_H; r++)
                     for (int c = 0; c < OUT_W; c++)
                        expQ.push_back('{k, r, c});
            end
         end
      end
   end

   // Directed scenarios layered on top of the randomized partners.
   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      cfg_s = 1'b0;
      #1 rst_n = 1'b0;
      #1 checkAllZero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Everything tied ready: exact pass length.
      wAckPct = 100; winAckPct = 100; readyPct = 100;
      repeat (2) @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b1);
      cycles = 1;
      while (!done && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("pass_cycles", 32'(cycles), 32'(PASS_CYCLES));
      repeat (2) @(negedge clk);

      // The writer stalls in EMIT while the element output keeps toggling.
      readyPct = 0;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0);
      cycles = 0;
      while (!res_valid && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("stall_reach_emit", 32'(res_valid), 1);
      savedData = res_data;
      repeat (5) begin
         @(negedge clk);
         checkOutput("stall_res_valid", 32'(res_valid), 1);
         checkOutput("stall_res_data", 32'(res_data), 32'(savedData));
         checkOutput("stall_no_win_req", 32'(win_req), 0);
      end
      readyPct = 100;
      waitDone(500);
      repeat (2) @(negedge clk);

      // Abort together with res_ready at kernel 0, row 1, column 0.
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0);
      cycles = 0;
      while (!(res_valid && res_row == 1 && res_col == 0) && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("abort_target_reached", 32'(res_valid), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_busy", 32'(busy), 0);
      checkOutput("abort_res_valid", 32'(res_valid), 0);
      checkOutput("abort_no_done", 32'(done), 0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitDone(500);
      repeat (2) @(negedge clk);

      // Start while busy, then a reset in the middle of FETCH.
      winAckPct = 0;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0);
      cycles = 0;
      while (!win_req && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("fetch_reached", 32'(win_req), 1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("busy_start_no_restart_w_req", 32'(w_req), 0);
      checkOutput("busy_start_still_fetch", 32'(win_req), 1);
      checkOutput("busy_start_pe_s", 32'(pe_s), 0);
      #2 rst_n = 1'b0;
      #1 checkAllZero("midpass_reset");
      @(negedge clk);
      rst_n = 1'b1;
      winAckPct = 100;
      repeat (3) @(negedge clk);
      checkOutput("post_reset_idle", 32'(busy), 0);

      // Randomized passes, each with an ignored start in the middle.
      for (int p = 0; p < 4; p++) begin
         wAckPct   = 30 + int'($urandom_range(70));
         winAckPct = 30 + int'($urandom_range(70));
         readyPct  = 30 + int'($urandom_range(70));
         applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)));
         repeat (int'($urandom_range(20, 5))) @(negedge clk);
         applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)));
         waitDone(3000);
         repeat (2) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Last-resort guard in case a wait loop itself is broken.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
